// File: rtl/ncl_ula_sink_if.sv
// Handshake bundle between the NCL ALU stage, the sink and its single-rail consumer.
interface ncl_ula_sink_if #(
  parameter int unsigned WIDTH = 4
);
  logic [2*WIDTH-1:0] soma;
  logic [1:0]         of;
  logic [1:0]         neg;
  logic [1:0]         zero;
  logic               ack_ula;
  logic [WIDTH-1:0]   result_data;
  logic [2:0]         result_flags;
  logic               result_valid;
  logic               result_ready;
  logic               illegal_err;
  logic               timeout_err;

  modport master (
    output soma, of, neg, zero, result_ready,
    input  ack_ula, result_data, result_flags, result_valid, illegal_err, timeout_err
  );

  modport slave (
    input  soma, of, neg, zero, result_ready,
    output ack_ula, result_data, result_flags, result_valid, illegal_err, timeout_err
  );
endinterface

// File: rtl/ncl_ula_sink.sv
// Clocked sink for the NCL dual-rail ALU stage: synchronise, check completeness, ack, emit word.
// Optional watchdog compiled in with `define ULA_SINK_TIMEOUT_EN.
module ncl_ula_sink #(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned STABLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  ncl_ula_sink_if.slave   bus
);

  localparam int unsigned NPAIR = WIDTH + 3;
  localparam int unsigned VW    = 2 * NPAIR;
  localparam int unsigned SCW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SCW-1:0] SC_MAX = SCW'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("ncl_ula_sink: STABLE_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic {ST_RFD = 1'b0, ST_RFN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [VW-1:0]     sync1_q, sync2_q;
  logic [SCW-1:0]    scnt_q, scnt_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [2:0]        flags_q, flags_d;
  logic              valid_q, valid_d;
  logic              ill_q, ill_d;

  logic              stable_c;
  logic              all_data_c;
  logic              all_null_c;
  logic              any_ill_c;
  logic [NPAIR-1:0]  word_c;

  // Pair order in the vector: soma bits, then of, neg, zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {bus.zero, bus.neg, bus.of, bus.soma};
      sync2_q <= sync1_q;
    end
  end

  // Restart the count on the edge the synchronised vector changes; saturate once stable.
  always_comb begin
    scnt_d = scnt_q;
    if (sync1_q != sync2_q) begin
      scnt_d = '0;
    end else if (scnt_q != SC_MAX) begin
      scnt_d = scnt_q + SCW'(1);
    end
  end

  assign stable_c = (scnt_q == SC_MAX);

  always_comb begin
    logic [1:0] pair;
    pair       = 2'b00;
    all_data_c = 1'b1;
    all_null_c = 1'b1;
    any_ill_c  = 1'b0;
    word_c     = '0;
    for (int i = 0; i < int'(NPAIR); i++) begin
      pair       = sync2_q[2*i +: 2];
      all_data_c = all_data_c & ((pair == 2'b01) | (pair == 2'b10));
      all_null_c = all_null_c & (pair == 2'b00);
      any_ill_c  = any_ill_c | (pair == 2'b11);
      word_c[i]  = pair[1];
    end
  end

  // FSM next state and output register updates.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    flags_d = flags_q;
    valid_d = valid_q;
    ill_d   = ill_q;

    if (valid_q && bus.result_ready) begin
      valid_d = 1'b0;
    end

    if (stable_c && any_ill_c) begin
      ill_d = 1'b1;
    end else if (stable_c) begin
      unique case (state_q)
        ST_RFD: begin
          if (all_data_c && (!valid_q || bus.result_ready)) begin
            data_d  = word_c[WIDTH-1:0];
            flags_d = {word_c[WIDTH], word_c[WIDTH+1], word_c[WIDTH+2]};
            valid_d = 1'b1;
            state_d = ST_RFN;
          end
        end
        ST_RFN: begin
          if (all_null_c) begin
            state_d = ST_RFD;
          end
        end
        default: state_d = ST_RFD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RFD;
      scnt_q  <= '0;
      data_q  <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.ack_ula      = (state_q == ST_RFD);
  assign bus.result_data  = data_q;
  assign bus.result_flags = flags_q;
  assign bus.result_valid = valid_q;
  assign bus.illegal_err  = ill_q;

`ifdef ULA_SINK_TIMEOUT_EN
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic           tmo_q, tmo_d;

  // Wait-time counter restarts on every state change (a capture is one); saturates at the limit.
  always_comb begin
    tcnt_d = tcnt_q;
    tmo_d  = tmo_q;
    if (state_d != state_q) begin
      tcnt_d = '0;
    end else if (tcnt_q != TCW'(TIMEOUT_CYCLES)) begin
      tcnt_d = tcnt_q + TCW'(1);
    end
    if (tcnt_d == TCW'(TIMEOUT_CYCLES)) begin
      tmo_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tmo_q  <= tmo_d;
    end
  end

  assign bus.timeout_err = tmo_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ncl_ula_sink.sv
// Self-checking bench for ncl_ula_sink: directed scenarios plus randomized wavefronts vs a queue model.
module tb_ncl_ula_sink;

  localparam int unsigned W     = 4;
  localparam int unsigned S     = 2;
  localparam int unsigned LAT   = 2 + S;
  localparam int unsigned NPAIR = W + 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  logic [6:0]  exp_q[$];
  logic [6:0]  exp_w;
  logic        mon_en = 1'b0;
  logic        rnd_done;

  ncl_ula_sink_if #(.WIDTH(W)) bus ();

  ncl_ula_sink #(
    .WIDTH(W), .STABLE_CYCLES(S), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] rail(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_raw(input logic [7:0] s, input logic [1:0] o, input logic [1:0] n, input logic [1:0] z);
    bus.soma = s; bus.of = o; bus.neg = n; bus.zero = z;
  endtask

  function automatic logic [2*NPAIR-1:0] enc(input logic [W-1:0] d, input logic [2:0] f);
    logic [2*NPAIR-1:0] v;
    for (int i = 0; i < int'(W); i++) v[2*i +: 2] = rail(d[i]);
    v[2*W +: 2]     = rail(f[2]);
    v[2*W + 2 +: 2] = rail(f[1]);
    v[2*W + 4 +: 2] = rail(f[0]);
    return v;
  endfunction

  task automatic set_vec(input logic [2*NPAIR-1:0] v);
    bus.soma = v[2*W-1:0];
    bus.of   = v[2*W +: 2];
    bus.neg  = v[2*W + 2 +: 2];
    bus.zero = v[2*W + 4 +: 2];
  endtask

  task automatic set_null();
    set_raw(8'h00, 2'b00, 2'b00, 2'b00);
  endtask

  task automatic wait_ack(input logic lvl, input int budget, input string tag);
    int k;
    k = 0;
    while (bus.ack_ula !== lvl && k < budget) begin
      step(1);
      k++;
    end
    check(tag, bus.ack_ula, lvl);
  endtask

  task automatic do_reset();
    set_null();
    rst_n = 1'b0;
    step(2);
    check("rst_ack", bus.ack_ula, 1);
    check("rst_valid", bus.result_valid, 0);
    check("rst_illegal", bus.illegal_err, 0);
    check("rst_timeout", bus.timeout_err, 0);
    rst_n = 1'b1;
    step(1);
  endtask

  // Every accepted word must be the oldest complete wavefront still outstanding.
  always @(negedge clk) begin
    if (mon_en && bus.result_valid && bus.result_ready) begin
      check("rnd_queue_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check("rnd_word", {bus.result_data, bus.result_flags}, exp_w);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]       d;
    logic [2:0]         f;
    logic [2*NPAIR-1:0] v;
    int                 np;
    int                 k;

    bus.result_ready = 1'b1;
    set_null();
    do_reset();

    // Single wavefront with consumer ready.
    set_raw(8'h66, 2'b01, 2'b01, 2'b01);
    step(LAT - 1);
    check("t2_ack_before", bus.ack_ula, 1);
    check("t2_valid_before", bus.result_valid, 0);
    step(1);
    check("t2_ack", bus.ack_ula, 0);
    check("t2_valid", bus.result_valid, 1);
    check("t2_data", bus.result_data, 4'h5);
    check("t2_flags", bus.result_flags, 3'b000);
    step(1);
    check("t2_valid_pulse", bus.result_valid, 0);
    set_null();
    step(LAT - 1);
    check("t2_null_ack_before", bus.ack_ula, 0);
    step(1);
    check("t2_null_ack", bus.ack_ula, 1);

    // Backpressure: second wavefront stalls while the register is occupied.
    bus.result_ready = 1'b0;
    set_raw(8'h66, 2'b01, 2'b01, 2'b01);
    step(LAT);
    check("t3_first_ack", bus.ack_ula, 0);
    check("t3_first_data", bus.result_data, 4'h5);
    set_null();
    step(LAT);
    check("t3_null_ack", bus.ack_ula, 1);
    set_raw(8'h99, 2'b01, 2'b01, 2'b01);
    step(10);
    check("t3_stall_ack", bus.ack_ula, 1);
    check("t3_stall_data", bus.result_data, 4'h5);
    check("t3_stall_valid", bus.result_valid, 1);
    bus.result_ready = 1'b1;
    step(1);
    check("t3_second_data", bus.result_data, 4'hA);
    check("t3_second_valid", bus.result_valid, 1);
    check("t3_second_ack", bus.ack_ula, 0);
    step(1);
    check("t3_drained", bus.result_valid, 0);
    set_null();
    wait_ack(1'b1, 20, "t3_ack_back");

    // Partial wavefront is ignored until completed.
    set_raw(8'h62, 2'b01, 2'b01, 2'b01);
    step(10);
    check("t4_partial_ack", bus.ack_ula, 1);
    check("t4_partial_valid", bus.result_valid, 0);
    set_raw(8'h66, 2'b01, 2'b01, 2'b01);
    step(LAT);
    check("t4_ack", bus.ack_ula, 0);
    check("t4_data", bus.result_data, 4'h5);
    step(1);
    set_null();
    wait_ack(1'b1, 20, "t4_ack_back");

    // Illegal pair: sticky error, no capture, state held.
    set_raw(8'h66, 2'b01, 2'b01, 2'b11);
    step(10);
    check("t5_illegal", bus.illegal_err, 1);
    check("t5_ack", bus.ack_ula, 1);
    check("t5_valid", bus.result_valid, 0);
    set_null();
    step(10);
    check("t5_illegal_sticky", bus.illegal_err, 1);
    do_reset();

    // Watchdog while NULL is withheld, then asynchronous reset mid-wavefront.
    set_raw(8'h66, 2'b01, 2'b01, 2'b01);
    step(LAT);
    check("t6_ack", bus.ack_ula, 0);
    step(15);
    check("t6_tmo_early", bus.timeout_err, 0);
    step(10);
`ifdef ULA_SINK_TIMEOUT_EN
    check("t6_tmo_set", bus.timeout_err, 1);
`else
    check("t6_tmo_off", bus.timeout_err, 0);
`endif
    bus.result_ready = 1'b0;
    set_raw(8'h99, 2'b01, 2'b01, 2'b01);
    step(1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_arst_ack", bus.ack_ula, 1);
    check("t6_arst_valid", bus.result_valid, 0);
    check("t6_arst_data", bus.result_data, 0);
    check("t6_arst_tmo", bus.timeout_err, 0);
    bus.result_ready = 1'b1;
    set_null();
    step(2);
    rst_n = 1'b1;
    step(1);

    // Randomized wavefronts with random consumer backpressure.
    mon_en   = 1'b1;
    rnd_done = 1'b0;
    fork
      begin
        for (int t = 0; t < 40; t++) begin
          d = W'($urandom);
          f = 3'($urandom);
          v = enc(d, f);
          np = int'($urandom_range(0, 4));
          if (np > 0) begin
            k = int'($urandom_range(0, NPAIR - 1));
            v[2*k +: 2] = 2'b00;
            set_vec(v);
            step(np + LAT);
            check("rnd_partial_ack", bus.ack_ula, 1);
          end
          set_vec(enc(d, f));
          exp_q.push_back({d, f});
          wait_ack(1'b0, 300, "rnd_ack_fall");
          if (np > 2) begin
            v = enc(d, f);
            k = int'($urandom_range(0, NPAIR - 1));
            v[2*k +: 2] = 2'b00;
            set_vec(v);
            step(LAT + 2);
            check("rnd_partial_null_ack", bus.ack_ula, 0);
          end
          set_null();
          wait_ack(1'b1, 50, "rnd_ack_rise");
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.result_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.result_ready = 1'b1;
    k = 0;
    while (bus.result_valid && k < 20) begin
      step(1);
      k++;
    end
    check("rnd_drain_valid", bus.result_valid, 0);
    check("rnd_queue_empty", exp_q.size(), 0);
    check("rnd_illegal", bus.illegal_err, 0);
`ifndef ULA_SINK_TIMEOUT_EN
    check("rnd_tmo_off", bus.timeout_err, 0);
`endif
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
